// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between the CPU sequencer (master) and the datapath/memory (slave).
// The master drives strobes and selects; the slave drives status and the IR opcode.
interface cpu_control_sequencer_if;
  // run is a level enable sampled only in IDLE and on instr_done; there is no backpressure,
  // and a strobe is acted on by the datapath in the same cycle it is high.
  logic       run;
  logic [3:0] ir_opcode;
  logic       acc_zero;
  logic       pc_we;
  logic       pc_sel;
  logic       mar_we;
  logic       mar_sel;
  logic       mbr_we;
  logic       mbr_sel;
  logic       ir_we;
  logic       acc_we;
  logic       acc_sel;
  logic [3:0] alu_op;
  logic       mem_we;
  logic       instr_done;
  logic       halted;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  run, ir_opcode, acc_zero,
    output pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel, ir_we,
           acc_we, acc_sel, alu_op, mem_we, instr_done, halted, illegal, state
  );

  modport slave (
    output run, ir_opcode, acc_zero,
    input  pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel, ir_we,
           acc_we, acc_sel, alu_op, mem_we, instr_done, halted, illegal, state
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute control FSM for the 16-bit accumulator CPU.
// Define CTRL_SINGLE_STEP_EN to add the step input for single-instruction execution.
module cpu_control_sequencer #(
  parameter logic [3:0] HALT_OPCODE   = 4'hF,
  parameter int         ILLEGAL_HALTS = 1
) (
  input  logic clock,
  input  logic reset_n,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic step,
`endif
  cpu_control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_F_MAR, S_F_READ, S_F_MBR, S_F_IR, S_DECODE,
    S_E_READ, S_E_MBR, S_E_ACC, S_E_SMBR, S_E_SWR, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;

  state_t state;
  logic   illegal_q;
  logic   done;
  logic   step_mode;
  state_t done_next;

`ifdef CTRL_SINGLE_STEP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          step_mode <= 1'b0;
    else if (state == S_IDLE && !bus.run)  step_mode <= step;
    else if (done)                         step_mode <= 1'b0;
  end
`else
  assign step_mode = 1'b0;
`endif

  assign done_next = (bus.run && !step_mode) ? S_F_MAR : S_IDLE;
  assign bus.state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else if (done) begin
      state <= done_next;
    end else begin
      case (state)
        S_IDLE: begin
`ifdef CTRL_SINGLE_STEP_EN
          if (bus.run || step) state <= S_F_MAR;
`else
          if (bus.run) state <= S_F_MAR;
`endif
        end
        S_F_MAR:  state <= S_F_READ;
        S_F_READ: state <= S_F_MBR;
        S_F_MBR:  state <= S_F_IR;
        S_F_IR:   state <= S_DECODE;
        S_DECODE: begin
          // Jumps and NOP-mode opcodes finish in DECODE via done; what is left here is multi-cycle or halting.
          if (bus.ir_opcode == HALT_OPCODE) state <= S_HALT;
          else begin
            case (bus.ir_opcode)
              OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= S_E_READ;
              OP_STORE:                                       state <= S_E_SMBR;
              OP_SHL, OP_SHR:                                 state <= S_E_ACC;
              default: begin
                state     <= S_HALT;
                illegal_q <= 1'b1;
              end
            endcase
          end
        end
        S_E_READ: state <= S_E_MBR;
        S_E_MBR:  state <= S_E_ACC;
        S_E_SMBR: state <= S_E_SWR;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pc_we = 1'b0;  bus.pc_sel = 1'b0;  bus.mar_we = 1'b0; bus.mar_sel = 1'b0;
    bus.mbr_we = 1'b0; bus.mbr_sel = 1'b0; bus.ir_we = 1'b0;  bus.acc_we = 1'b0;
    bus.acc_sel = 1'b0; bus.alu_op = 4'b0000; bus.mem_we = 1'b0;
    bus.halted = 1'b0; bus.illegal = 1'b0;
    done = 1'b0;
    case (state)
      S_F_MAR: bus.mar_we = 1'b1;
      S_F_MBR: bus.mbr_we = 1'b1;
      S_F_IR: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
      end
      S_DECODE: begin
        if (bus.ir_opcode != HALT_OPCODE) begin
          case (bus.ir_opcode)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              bus.mar_we  = 1'b1;
              bus.mar_sel = 1'b1;
            end
            OP_JUMP: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = 1'b1;
              done       = 1'b1;
            end
            OP_JZ: begin
              bus.pc_we  = bus.acc_zero;
              bus.pc_sel = bus.acc_zero;
              done       = 1'b1;
            end
            OP_STORE, OP_SHL, OP_SHR: ;
            default: done = (ILLEGAL_HALTS == 0);
          endcase
        end
      end
      S_E_MBR: bus.mbr_we = 1'b1;
      S_E_ACC: begin
        bus.acc_we = 1'b1;
        done       = 1'b1;
        case (bus.ir_opcode)
          OP_LOAD: bus.acc_sel = 1'b1;
          OP_SUB:  bus.alu_op  = 4'b0001;
          OP_SHL:  bus.alu_op  = 4'b0100;
          OP_SHR:  bus.alu_op  = 4'b0101;
          OP_AND:  bus.alu_op  = 4'b1000;
          OP_OR:   bus.alu_op  = 4'b1001;
          OP_XOR:  bus.alu_op  = 4'b1010;
          default: bus.alu_op  = 4'b0000;
        endcase
      end
      S_E_SMBR: begin
        bus.mbr_we  = 1'b1;
        bus.mbr_sel = 1'b1;
      end
      S_E_SWR: begin
        bus.mem_we = 1'b1;
        done       = 1'b1;
      end
      S_HALT: begin
        bus.halted  = 1'b1;
        bus.illegal = illegal_q;
      end
      default: ;
    endcase
  end

  assign bus.instr_done = done;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: per-cycle expected output vectors are queued
// from the instruction timing table and compared as the sequencer steps through each cycle.
module tb_cpu_control_sequencer;

  // Output vector layout used by expectations and observations.
  localparam logic [16:0] PC_WE   = 17'h10000;
  localparam logic [16:0] PC_SEL  = 17'h08000;
  localparam logic [16:0] MAR_WE  = 17'h04000;
  localparam logic [16:0] MAR_SEL = 17'h02000;
  localparam logic [16:0] MBR_WE  = 17'h01000;
  localparam logic [16:0] MBR_SEL = 17'h00800;
  localparam logic [16:0] IR_WE   = 17'h00400;
  localparam logic [16:0] ACC_WE  = 17'h00200;
  localparam logic [16:0] ACC_SEL = 17'h00100;
  localparam logic [16:0] MEM_WE  = 17'h00008;
  localparam logic [16:0] DONE    = 17'h00004;
  localparam logic [16:0] HALTED  = 17'h00002;
  localparam logic [16:0] ILLEGAL = 17'h00001;
  localparam logic [16:0] NONE    = 17'h00000;

  logic       clock;
  logic       reset_n;
  logic       run;
  logic [3:0] ir_opcode;
  logic       acc_zero;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif

  logic [16:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  cpu_control_sequencer_if bus();
  cpu_control_sequencer_if bus_nop();

  assign bus.run = run;          assign bus.ir_opcode = ir_opcode;     assign bus.acc_zero = acc_zero;
  assign bus_nop.run = run;      assign bus_nop.ir_opcode = ir_opcode; assign bus_nop.acc_zero = acc_zero;

  cpu_control_sequencer #(.HALT_OPCODE(4'hF), .ILLEGAL_HALTS(1)) dut (
    .clock(clock), .reset_n(reset_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(bus)
  );

  cpu_control_sequencer #(.HALT_OPCODE(4'hF), .ILLEGAL_HALTS(0)) dut_nop (
    .clock(clock), .reset_n(reset_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(bus_nop)
  );

  logic [16:0] obs, obs_nop;
  assign obs = {bus.pc_we, bus.pc_sel, bus.mar_we, bus.mar_sel, bus.mbr_we, bus.mbr_sel,
                bus.ir_we, bus.acc_we, bus.acc_sel, bus.alu_op, bus.mem_we,
                bus.instr_done, bus.halted, bus.illegal};
  assign obs_nop = {bus_nop.pc_we, bus_nop.pc_sel, bus_nop.mar_we, bus_nop.mar_sel,
                    bus_nop.mbr_we, bus_nop.mbr_sel, bus_nop.ir_we, bus_nop.acc_we,
                    bus_nop.acc_sel, bus_nop.alu_op, bus_nop.mem_we,
                    bus_nop.instr_done, bus_nop.halted, bus_nop.illegal};

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [16:0] alu(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      4'h3:    code = 4'b0001;
      4'h4:    code = 4'b1000;
      4'h5:    code = 4'b1001;
      4'h6:    code = 4'b1010;
      4'h7:    code = 4'b0100;
      4'h8:    code = 4'b0101;
      default: code = 4'b0000;
    endcase
    return {9'b0, code, 4'b0};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
    checks++;
    assert (got === want) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // driver tasks
  task automatic do_reset(input logic [3:0] op, input logic az, input logic r);
    @(negedge clock);
    reset_n = 1'b0;
    run = r; ir_opcode = op; acc_zero = az;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(negedge clock);
    check("reset", obs, NONE);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("idle_after_reset", obs, NONE);
  endtask

  task automatic push_fetch();
    exp_q.push_back(MAR_WE);
    exp_q.push_back(NONE);
    exp_q.push_back(MBR_WE);
    exp_q.push_back(IR_WE | PC_WE);
  endtask

  task automatic push_instr(input logic [3:0] op, input logic az);
    push_fetch();
    case (op)
      4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        exp_q.push_back(MAR_WE | MAR_SEL);
        exp_q.push_back(NONE);
        exp_q.push_back(MBR_WE);
        exp_q.push_back(ACC_WE | DONE | ((op == 4'h0) ? ACC_SEL : alu(op)));
      end
      4'h1: begin
        exp_q.push_back(NONE);
        exp_q.push_back(MBR_WE | MBR_SEL);
        exp_q.push_back(MEM_WE | DONE);
      end
      4'h7, 4'h8: begin
        exp_q.push_back(NONE);
        exp_q.push_back(ACC_WE | DONE | alu(op));
      end
      4'h9:    exp_q.push_back(PC_WE | PC_SEL | DONE);
      4'hA:    exp_q.push_back(az ? (PC_WE | PC_SEL | DONE) : DONE);
      default: exp_q.push_back(NONE);
    endcase
  endtask

  task automatic drain(input string tag, input int drop_at);
    int c = 0;
    while (exp_q.size() > 0) begin
      @(posedge clock);
      #1;
      c++;
      check(tag, obs, exp_q.pop_front());
      if (c == drop_at) begin
        run = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
`endif
      end
    end
  endtask

  initial begin
    logic [3:0] alu_ops[5];
    alu_ops = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h8};
    reset_n = 1'b0; run = 1'b0; ir_opcode = 4'h0; acc_zero = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif

    do_reset(4'h0, 1'b0, 1'b1);
    push_instr(4'h0, 1'b0);
    exp_q.push_back(MAR_WE);
    drain("load", 0);

    do_reset(4'h3, 1'b0, 1'b1);
    push_instr(4'h3, 1'b0);
    drain("sub", 0);
    do_reset(4'h7, 1'b1, 1'b1);
    push_instr(4'h7, 1'b1);
    exp_q.push_back(MAR_WE);
    drain("shl", 0);

    foreach (alu_ops[i]) begin
      logic az;
      az = 1'($urandom_range(1, 0));
      do_reset(alu_ops[i], az, 1'b1);
      push_instr(alu_ops[i], az);
      drain("alu_op", 0);
    end

    do_reset(4'h1, 1'b0, 1'b1);
    push_instr(4'h1, 1'b0);
    exp_q.push_back(MAR_WE);
    drain("store", 0);

    do_reset(4'hA, 1'b0, 1'b1);
    push_instr(4'hA, 1'b0);
    exp_q.push_back(MAR_WE);
    drain("jz_not_taken", 0);
    do_reset(4'hA, 1'b1, 1'b1);
    push_instr(4'hA, 1'b1);
    drain("jz_taken", 0);
    do_reset(4'h9, 1'b0, 1'b1);
    push_instr(4'h9, 1'b0);
    exp_q.push_back(MAR_WE);
    drain("jump", 0);

    // illegal opcode: the halting instance stops, the NOP instance completes in 5 cycles
    do_reset(4'hB, 1'b0, 1'b1);
    push_instr(4'hB, 1'b0);
    repeat (20) exp_q.push_back(HALTED | ILLEGAL);
    for (int c = 1; c <= 25; c++) begin
      @(posedge clock);
      #1;
      check("illegal_halt", obs, exp_q.pop_front());
      if (c == 4) check("nop_fetch", obs_nop, IR_WE | PC_WE);
      if (c == 5) check("nop_done", obs_nop, DONE);
      if (c == 6) check("nop_next", obs_nop, MAR_WE);
    end

    do_reset(4'hF, 1'b0, 1'b1);
    push_instr(4'hF, 1'b0);
    repeat (5) exp_q.push_back(HALTED);
    drain("halt", 0);

    // reset_n in E_SMBR aborts the store immediately
    do_reset(4'h1, 1'b0, 1'b1);
    push_fetch();
    exp_q.push_back(NONE);
    exp_q.push_back(MBR_WE | MBR_SEL);
    drain("store_pre_abort", 0);
    #2 reset_n = 1'b0;
    #1 check("abort_immediate", obs, NONE);
    repeat (4) begin
      @(negedge clock);
      check("abort_hold", obs, NONE);
    end
    run = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clock);
      #1 check("abort_no_mem_we", obs, NONE);
    end

    // run dropped during fetch: the instruction still completes, then IDLE
    do_reset(4'h0, 1'b0, 1'b1);
    push_instr(4'h0, 1'b0);
    repeat (3) exp_q.push_back(NONE);
    drain("run_drop", 3);

`ifdef CTRL_SINGLE_STEP_EN
    do_reset(4'h0, 1'b0, 1'b0);
    step = 1'b1;
    push_instr(4'h0, 1'b0);
    repeat (4) exp_q.push_back(NONE);
    drain("single_step", 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
